// File: rtl/alu_pkg.sv
// alu_pkg: ALUControl codes and arbiter FSM state encodings shared by the ALU and its arbiter.
package alu_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu.sv
// alu: 32-bit add/sub/and/or/slt; unsupported codes produce 0.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUControl,
    output logic [31:0] Result
);
    logic [31:0] sum;
    // SUB and SLT share one adder as A + ~B + 1; SLT is the raw sign bit, no overflow fix-up
    assign sum = A + (ALUControl[0] ? ~B : B) + {31'b0, ALUControl[0]};
    always_comb
        Result = (ALUControl == ALU_ADD || ALUControl == ALU_SUB) ? sum :
                 ALUControl == ALU_AND ? (A & B) :
                 ALUControl == ALU_OR  ? (A | B) :
                 ALUControl == ALU_SLT ? {31'b0, sum[31]} : '0;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin (or fixed-priority) sharing of one ALU between two
// requesters, one op in flight, result held until the consumer takes it.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 3,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic              busy
);
    state_t            state;
    logic              last_id;
    logic              grant1;
    logic              idle;
    logic [DATA_W-1:0] a_q, b_q, alu_result;
    logic [CTRL_W-1:0] ctrl_q;
    assign idle       = state == IDLE && !rst;
    // on a tie the requester that did not win last time gets the ALU
    assign grant1     = req1_valid && (!req0_valid || (FIXED_PRIO == 0 && !last_id));
    assign req0_ready = idle && req0_valid && !grant1;
    assign req1_ready = idle && grant1;
    assign rsp_valid  = state == RESP;
    assign busy       = state != IDLE;
    alu u_alu (
        .A         (a_q),
        .B         (b_q),
        .ALUControl(ctrl_q),
        .Result    (alu_result)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_id     <= 1'b1;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    a_q     <= grant1 ? req1_a : req0_a;
                    b_q     <= grant1 ? req1_b : req0_b;
                    ctrl_q  <= grant1 ? req1_ctrl : req0_ctrl;
                    rsp_id  <= grant1;
                    last_id <= grant1;
                    state   <= EXEC;
                end
                EXEC: begin
                    rsp_result  <= alu_result;
                    rsp_zero    <= alu_result == '0;
                    rsp_illegal <= !(ctrl_q inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT});
                    state       <= RESP;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of the shared-ALU arbiter
// against a transaction-level reference model.
module tb_alu_share_arbiter;
    logic        clk = 0;
    logic        rst;
    logic        rv[2];
    logic [31:0] ra[2], rb[2];
    logic [2:0]  rc[2];
    logic        r0r, r1r, rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal, busy;
    logic [31:0] rsp_result;
    logic        f0r, f1r, f_valid, f_id, f_zero, f_illegal, f_busy;
    logic [31:0] f_result;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(rv[0]), .req0_ready(r0r), .req0_a(ra[0]), .req0_b(rb[0]), .req0_ctrl(rc[0]),
        .req1_valid(rv[1]), .req1_ready(r1r), .req1_a(ra[1]), .req1_b(rb[1]), .req1_ctrl(rc[1]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal), .busy(busy)
    );

    alu_share_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(rv[0]), .req0_ready(f0r), .req0_a(ra[0]), .req0_b(rb[0]), .req0_ctrl(rc[0]),
        .req1_valid(rv[1]), .req1_ready(f1r), .req1_a(ra[1]), .req1_b(rb[1]), .req1_ctrl(rc[1]),
        .rsp_valid(f_valid), .rsp_ready(rsp_ready), .rsp_id(f_id), .rsp_result(f_result),
        .rsp_zero(f_zero), .rsp_illegal(f_illegal), .busy(f_busy)
    );

    // reference ALU: {illegal, result}
    function automatic logic [32:0] model(input logic [31:0] a, b, input logic [2:0] c);
        logic [31:0] d;
        d = a - b;
        case (c)
            3'd0: return {1'b0, a + b};
            3'd1: return {1'b0, d};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd5: return {1'b0, 31'b0, d[31]};
            default: return {1'b1, 32'b0};
        endcase
    endfunction

    function automatic logic [31:0] rnd();
        return $urandom_range(1) ? $urandom() : 32'($urandom_range(3));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; rv[0] = 0; rv[1] = 0; rsp_ready = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic do_op(input int id, input logic [31:0] a, b, input logic [2:0] c,
                         output logic [31:0] r, output logic z, il, rid, output bit to);
        bit acc = 0, got = 0;
        rv[id] = 1; ra[id] = a; rb[id] = b; rc[id] = c; rsp_ready = 0;
        r = 'x; z = 'x; il = 'x; rid = 'x;
        for (int k = 0; k < 10 && !acc; k++) begin
            #1;
            acc = (id == 0) ? r0r : r1r;
            tick();
        end
        rv[id] = 0;
        for (int k = 0; k < 10 && acc && !got; k++) begin
            if (rsp_valid) begin
                got = 1; r = rsp_result; z = rsp_zero; il = rsp_illegal; rid = rsp_id;
            end else tick();
        end
        to = !(acc && got);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; rv[0] = 1; rv[1] = 1; ra[0] = 1; rb[0] = 2; rc[0] = 0; ra[1] = 3; rb[1] = 4; rc[1] = 0;
        rsp_ready = 0;
        #1;
        vectors++;
        if (r0r !== 0 || r1r !== 0) begin
            miscompares++; $display("FAIL reset_ready: got %b%b want 00", r0r, r1r);
        end
        tick(); tick();
        rv[0] = 0; rv[1] = 0;
        #1;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b id=%b r=%h z=%b il=%b busy=%b want all 0",
                     rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal, busy);
        end
        rst = 0;
        rv[0] = 1; ra[0] = 5; rb[0] = 7; rc[0] = 3'b000;
        tick();
        rv[0] = 0; rst = 1; rv[0] = 1;
        #1;
        vectors++;
        if (r0r !== 0 || busy !== 1) begin
            miscompares++; $display("FAIL midop_pre: got ready=%b busy=%b want 0/1", r0r, busy);
        end
        tick();
        rst = 0; rv[0] = 0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal, busy} !== '0) begin
                miscompares++;
                $display("FAIL midop_reset: got v=%b r=%h busy=%b want all 0", rsp_valid, rsp_result, busy);
            end
            tick();
        end
    endtask

    task automatic test_single();
        do_reset();
        rv[0] = 1; ra[0] = 10; rb[0] = 3; rc[0] = 3'b001;
        #1;
        vectors++;
        if (r0r !== 1) begin miscompares++; $display("FAIL single_ready: got %b want 1", r0r); end
        tick();
        rv[0] = 0;
        vectors++;
        if (rsp_valid !== 0) begin miscompares++; $display("FAIL single_n1: got valid %b want 0", rsp_valid); end
        tick();
        vectors++;
        if (rsp_valid !== 1 || rsp_result !== 32'd7 || rsp_id !== 0 || rsp_zero !== 0 || rsp_illegal !== 0) begin
            miscompares++;
            $display("FAIL single_rsp: got v=%b r=%0d id=%b z=%b il=%b want 1/7/0/0/0",
                     rsp_valid, rsp_result, rsp_id, rsp_zero, rsp_illegal);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        vectors++;
        if (busy !== 0) begin miscompares++; $display("FAIL single_done: busy %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int g[$], ids[$];
        do_reset();
        rv[0] = 1; rv[1] = 1; ra[0] = 1; rb[0] = 1; rc[0] = 0; ra[1] = 2; rb[1] = 2; rc[1] = 0;
        rsp_ready = 1;
        for (int k = 0; k < 20 && ids.size() < 4; k++) begin
            #1;
            if (r0r) g.push_back(0);
            if (r1r) g.push_back(1);
            if (rsp_valid) ids.push_back(int'(rsp_id));
            tick();
        end
        rv[0] = 0; rv[1] = 0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= g.size() || k >= ids.size() || g[k] != k % 2 || ids[k] != k % 2) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got grant=%0d id=%0d want %0d", k,
                         k < g.size() ? g[k] : -1, k < ids.size() ? ids[k] : -1, k % 2);
            end
        end
        tick(); tick(); tick();
        rsp_ready = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic id;
        bit got = 0;
        do_reset();
        rv[1] = 1; ra[1] = 32'h00F0; rb[1] = 32'h0F00; rc[1] = 3'b011;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            rv[1] = 0;
            got = rsp_valid;
        end
        r = rsp_result; id = rsp_id;
        vectors++;
        if (!got || r !== 32'h0FF0 || id !== 1) begin
            miscompares++; $display("FAIL bp_rsp: got v=%b r=%h id=%b want 1/00000ff0/1", got, r, id);
        end
        rv[0] = 1; rv[1] = 1; ra[0] = 9; rb[0] = 9; rc[0] = 0; rb[1] = 1; rc[1] = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if (rsp_valid !== 1 || rsp_result !== r || rsp_id !== id || r0r !== 0 || r1r !== 0 || busy !== 1) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b r=%h rdy=%b%b busy=%b", k, rsp_valid, rsp_result, r0r, r1r, busy);
            end
            tick();
        end
        rsp_ready = 1;
        #1;
        vectors++;
        if (r0r !== 0 || r1r !== 0) begin miscompares++; $display("FAIL bp_consume_ready: got %b%b want 00", r0r, r1r); end
        tick();
        rsp_ready = 0;
        vectors++;
        if (busy !== 0 || rsp_valid !== 0 || r0r !== 1) begin
            miscompares++; $display("FAIL bp_idle: got busy=%b v=%b r0ready=%b want 0/0/1", busy, rsp_valid, r0r);
        end
        rv[0] = 0; rv[1] = 0;
    endtask

    task automatic test_slt_wrap_illegal();
        logic [31:0] a[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd3};
        logic [31:0] b[4] = '{32'd1, 32'd1, 32'd5, 32'd4};
        logic [2:0]  c[4] = '{3'b101, 3'b000, 3'b001, 3'b110};
        logic [31:0] er[4] = '{32'd1, 32'd0, 32'd0, 32'd0};
        logic        ez[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic        ei[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] r; logic z, il, rid; bit to;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_op(k % 2, a[k], b[k], c[k], r, z, il, rid, to);
            vectors++;
            if (to || r !== er[k] || z !== ez[k] || il !== ei[k] || rid !== 1'(k % 2)) begin
                miscompares++;
                $display("FAIL edge%0d: got to=%b r=%h z=%b il=%b id=%b want r=%h z=%b il=%b id=%0d",
                         k, to, r, z, il, rid, er[k], ez[k], ei[k], k % 2);
            end
        end
    endtask

    task automatic test_fixed_prio();
        int n0 = 0;
        do_reset();
        rv[0] = 1; rv[1] = 1; ra[0] = 4; rb[0] = 4; rc[0] = 0; ra[1] = 6; rb[1] = 6; rc[1] = 0;
        rsp_ready = 1;
        for (int k = 0; k < 12; k++) begin
            #1;
            vectors++;
            if (f1r !== 0 || (f_valid && f_id !== 0)) begin
                miscompares++; $display("FAIL fp_tie%0d: got r1ready=%b id=%b want 0/0", k, f1r, f_id);
            end
            if (f0r) n0++;
            tick();
        end
        vectors++;
        if (n0 != 4) begin miscompares++; $display("FAIL fp_count: got %0d grants want 4", n0); end
        rv[0] = 0; rv[1] = 0; rsp_ready = 0;
    endtask

    task automatic test_random();
        int phase = 0, ops = 0;
        bit last = 1, g;
        logic [32:0] exp = '0;
        bit eid = 0;
        do_reset();
        for (int cyc = 0; cyc < 800 && ops < 80; cyc++) begin
            for (int i = 0; i < 2; i++)
                if (!rv[i] && $urandom_range(2) == 0) begin
                    rv[i] = 1; ra[i] = rnd(); rb[i] = rnd(); rc[i] = 3'($urandom_range(7));
                end
            rsp_ready = $urandom_range(3) != 0;
            #1;
            g = rv[1] && (!rv[0] || !last);
            vectors++;
            if (r0r !== (phase == 0 && rv[0] && !g) || r1r !== (phase == 0 && g)) begin
                miscompares++; $display("FAIL rand_ready c%0d: got %b%b phase=%0d", cyc, r0r, r1r, phase);
            end
            vectors++;
            if (rsp_valid !== (phase == 2) || (phase == 2 && (rsp_id !== eid || rsp_result !== exp[31:0] ||
                rsp_illegal !== exp[32] || rsp_zero !== (exp[31:0] == 0)))) begin
                miscompares++;
                $display("FAIL rand_rsp c%0d: got v=%b id=%b r=%h il=%b z=%b want v=%b id=%b r=%h il=%b",
                         cyc, rsp_valid, rsp_id, rsp_result, rsp_illegal, rsp_zero, phase == 2, eid, exp[31:0], exp[32]);
            end
            tick();
            if (phase == 0 && (rv[0] || rv[1])) begin
                exp = model(ra[g], rb[g], rc[g]); eid = g; last = g; rv[g] = 0; phase = 1; ops++;
            end else if (phase == 1) phase = 2;
            else if (phase == 2 && rsp_ready) phase = 0;
        end
        rv[0] = 0; rv[1] = 0; rsp_ready = 0;
    endtask

    initial begin
        rv[0] = 0; rv[1] = 0; rsp_ready = 0; rst = 1;
        ra[0] = 0; rb[0] = 0; rc[0] = 0; ra[1] = 0; rb[1] = 0; rc[1] = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_slt_wrap_illegal();
        test_fixed_prio();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
